// File: rtl/guess_game_ctrl_pkg.sv
// Shared encodings and small helpers for the number-guessing game controller.
package guess_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOW  = 2'b01;
  localparam logic [1:0] RES_HIGH = 2'b10;
  localparam logic [1:0] RES_EQ   = 2'b11;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [3:0] LFSR_SEED   = 4'b0001;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;

  // Packed-BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    if (value == 8'h99) begin
      return value;
    end
    if (value[3:0] == 4'd9) begin
      return {value[7:4] + 4'd1, 4'd0};
    end
    return {value[7:4], value[3:0] + 4'd1};
  endfunction

  // Folds the 1..15 LFSR range onto a decimal digit.
  function automatic logic [3:0] lfsr_to_digit(input logic [3:0] lfsr);
    if (lfsr >= 4'd10) begin
      return lfsr - 4'd10;
    end
    return lfsr;
  endfunction

  function automatic logic [1:0] compare_digits(input logic [3:0] guess,
                                                input logic [3:0] secret);
    if (guess < secret) begin
      return RES_LOW;
    end
    if (guess > secret) begin
      return RES_HIGH;
    end
    return RES_EQ;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low push-button and emits one pulse per debounced press.
module key_debounce #(
  parameter logic [19:0] DB_CYCLES = 20'd1_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Key_In,
  output logic Press_Pulse
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        level_reg;
  logic [19:0] cnt_reg;

  // Idle level is 1 (released); a new level is taken only after DB_CYCLES differing samples.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      level_reg   <= 1'b1;
      cnt_reg     <= 20'd0;
      Press_Pulse <= 1'b0;
    end else begin
      sync1_reg   <= Key_In;
      sync2_reg   <= sync1_reg;
      Press_Pulse <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= 20'd0;
      end else if (cnt_reg == DB_CYCLES - 20'd1) begin
        cnt_reg     <= 20'd0;
        level_reg   <= sync2_reg;
        Press_Pulse <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 20'd1;
      end
    end
  end

endmodule

// File: rtl/guess_game_ctrl.sv
// Game controller: debounced keys, LFSR secret, guess/compare FSM with BCD try counter.
module guess_game_ctrl
  import guess_game_ctrl_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = 20'd1_000_000,
  parameter logic [7:0]  MAX_TRIES = 8'h10
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Key_New,
  input  logic       Key_Confirm,
  input  logic [3:0] Guess_In,
  output logic [3:0] data,
  output logic [7:0] tries,
  output logic [1:0] Result_Out,
  output logic       Win_Out,
  output logic       Lose_Out
);

  logic       new_p;
  logic       conf_p;
  logic [3:0] lfsr_reg;
  logic [3:0] secret_reg;
  state_t     state_reg;
  logic [7:0] tries_next;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_new (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Key_In      (Key_New),
    .Press_Pulse (new_p)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_confirm (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Key_In      (Key_Confirm),
    .Press_Pulse (conf_p)
  );

  // x^4+x^3+1, seeded non-zero so it cycles through all 15 non-zero states.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
    end
  end

  assign tries_next = bcd_inc(tries);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg  <= ST_IDLE;
      secret_reg <= 4'd0;
      data       <= BLANK_DIGIT;
      tries      <= 8'h00;
      Result_Out <= RES_NONE;
      Win_Out    <= 1'b0;
      Lose_Out   <= 1'b0;
    end else if (new_p) begin
      // A new-game press restarts from any state and outranks a simultaneous confirm.
      state_reg  <= ST_PLAY;
      secret_reg <= lfsr_to_digit(lfsr_reg);
      data       <= BLANK_DIGIT;
      tries      <= 8'h00;
      Result_Out <= RES_NONE;
      Win_Out    <= 1'b0;
      Lose_Out   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_IDLE;
        end
        ST_PLAY: begin
          if (conf_p && (Guess_In <= MAX_DIGIT)) begin
            data      <= Guess_In;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          tries      <= tries_next;
          Result_Out <= compare_digits(data, secret_reg);
          if (data == secret_reg) begin
            state_reg <= ST_WIN;
          end else if (tries_next == MAX_TRIES) begin
            state_reg <= ST_LOSE;
          end else begin
            state_reg <= ST_PLAY;
          end
        end
        ST_WIN: begin
          data    <= secret_reg;
          Win_Out <= 1'b1;
        end
        ST_LOSE: begin
          data     <= secret_reg;
          Lose_Out <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed and randomized checks of guess_game_ctrl against a behavioural game model.
module tb_guess_game_ctrl;

  localparam int DB       = 4;
  localparam int MAX_DEC  = 3;
  localparam int HOLD     = 10;
  localparam int SETTLE   = 10;

  logic       CLK;
  logic       RSTn;
  logic       Key_New;
  logic       Key_Confirm;
  logic [3:0] Guess_In;
  logic [3:0] data;
  logic [7:0] tries;
  logic [1:0] Result_Out;
  logic       Win_Out;
  logic       Lose_Out;

  int tests = 0;
  int fails = 0;
  int ncyc;

  // LFSR states after k advances from seed 0001 under x^4+x^3+1.
  int seq [0:14] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  // Game model: 0 idle, 1 playing, 2 won, 3 lost.
  int m_st, m_secret, m_tries, m_data, m_res;

  guess_game_ctrl #(.DB_CYCLES(20'd4), .MAX_TRIES(8'h03)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Key_New     (Key_New),
    .Key_Confirm (Key_Confirm),
    .Guess_In    (Guess_In),
    .data        (data),
    .tries       (tries),
    .Result_Out  (Result_Out),
    .Win_Out     (Win_Out),
    .Lose_Out    (Lose_Out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (!RSTn) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int digit_of(input int l);
    return (l >= 10) ? l - 10 : l;
  endfunction

  // Secret a new-game press driven now will capture (sync 2 + debounce DB, pulse, capture).
  function automatic int exp_secret();
    return digit_of(seq[(ncyc + 2 + DB) % 15]);
  endfunction

  task automatic model_reset();
    m_st = 0; m_secret = 0; m_tries = 0; m_data = 15; m_res = 0;
  endtask

  task automatic model_new(input int s);
    m_st = 1; m_secret = s; m_tries = 0; m_data = 15; m_res = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},  {4'h0, data},       8'(m_data));
    chk({tag, ".tries"}, tries,              to_bcd(m_tries));
    chk({tag, ".res"},   {6'h0, Result_Out}, 8'(m_res));
    chk({tag, ".win"},   {7'h0, Win_Out},    8'(m_st == 2));
    chk({tag, ".lose"},  {7'h0, Lose_Out},   8'(m_st == 3));
  endtask

  task automatic press_new(input int target, input string tag);
    int s;
    s = exp_secret();
    for (int w = 0; w < 30 && target >= 0 && s != target; w++) begin
      @(negedge CLK);
      s = exp_secret();
    end
    Key_New = 1'b0;
    repeat (HOLD) @(negedge CLK);
    Key_New = 1'b1;
    repeat (SETTLE) @(negedge CLK);
    model_new(s);
    $display("[TB] new game secret=%0d data=%0h tries=%0h res=%0d", s, data, tries, Result_Out);
    check_all(tag);
  endtask

  task automatic press_conf(input int g, input string tag);
    int cap_data;
    Guess_In = 4'(g);
    if (m_st == 1 && g <= 9) begin
      m_data = g;
      if (m_tries < 99) m_tries++;
      m_res = (g < m_secret) ? 1 : ((g > m_secret) ? 2 : 3);
      if (g == m_secret) m_st = 2;
      else if (m_tries == MAX_DEC) m_st = 3;
    end
    cap_data = m_data;
    if (m_st >= 2) m_data = m_secret;
    Key_Confirm = 1'b0;
    repeat (3 + DB) @(negedge CLK);
    chk({tag, ".lat_data"}, {4'h0, data}, 8'(cap_data));
    @(negedge CLK);
    chk({tag, ".lat_tries"}, tries, to_bcd(m_tries));
    chk({tag, ".lat_res"}, {6'h0, Result_Out}, 8'(m_res));
    @(negedge CLK);
    chk({tag, ".lat_win"},  {7'h0, Win_Out},  8'(m_st == 2));
    chk({tag, ".lat_lose"}, {7'h0, Lose_Out}, 8'(m_st == 3));
    repeat (HOLD - 5 - DB) @(negedge CLK);
    Key_Confirm = 1'b1;
    repeat (SETTLE) @(negedge CLK);
    $display("[TB] confirm guess=%0d data=%0h tries=%0h res=%0d win=%0b lose=%0b",
             g, data, tries, Result_Out, Win_Out, Lose_Out);
    check_all(tag);
  endtask

  initial begin
    int s;
    RSTn = 1'b0; Key_New = 1'b1; Key_Confirm = 1'b1; Guess_In = 4'd0;
    model_reset();

    // Reset values, then a short glitch on Key_New must be ignored.
    repeat (3) @(negedge CLK);
    check_all("reset");
    RSTn = 1'b1;
    Key_New = 1'b0;
    repeat (2) @(negedge CLK);
    Key_New = 1'b1;
    repeat (SETTLE) @(negedge CLK);
    $display("[TB] glitch on Key_New data=%0h tries=%0h", data, tries);
    check_all("glitch");

    // Secret 7: low, high, then equal on the last allowed try (win beats lose).
    press_new(7, "new7");
    press_conf(3, "g3");
    press_conf(9, "g9");
    press_conf(7, "g7");
    press_conf(2, "win_ignore");

    // Secret 5: three misses exhaust the tries.
    press_new(5, "new5");
    press_conf(1, "g1");
    press_conf(2, "g2");
    press_conf(3, "g3b");
    press_conf(5, "lose_ignore");

    // Out-of-range guess, then both keys in the same cycle.
    press_new(-1, "new_any");
    press_conf(4, "g4");
    press_conf(12, "g12");
    s = exp_secret();
    Key_New = 1'b0; Key_Confirm = 1'b0;
    repeat (HOLD) @(negedge CLK);
    Key_New = 1'b1; Key_Confirm = 1'b1;
    repeat (SETTLE) @(negedge CLK);
    model_new(s);
    $display("[TB] both keys secret=%0d data=%0h tries=%0h", s, data, tries);
    check_all("both");

    // Reset landing on the CHECK cycle.
    Guess_In = 4'(s == 0 ? 1 : 0);
    Key_Confirm = 1'b0;
    repeat (3 + DB) @(negedge CLK);
    RSTn = 1'b0; Key_Confirm = 1'b1;
    @(negedge CLK);
    model_reset();
    $display("[TB] reset in check data=%0h tries=%0h", data, tries);
    check_all("rst_check");
    RSTn = 1'b1;
    repeat (SETTLE) @(negedge CLK);
    check_all("rst_idle");

    // LFSR trajectory over 1000 cycles.
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      chk("lfsr", {4'h0, dut.lfsr_reg}, 8'(seq[ncyc % 15]));
    end
    $display("[TB] lfsr run done");

    // Randomized games.
    for (int gm = 0; gm < 6; gm++) begin
      press_new(-1, "rnd_new");
      for (int k = 0; k < 5; k++) begin
        press_conf(int'($urandom_range(0, 15)), "rnd_conf");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
